// File: rtl/cc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cc_pkg : shared constants for the punctured convolutional encoder     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cc_pkg;

  localparam int K = 7;
  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G2 = 7'o133;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10,
    RATE_5_6 = 2'b11
  } rate_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Bit p of a mask is the keep flag for puncture phase p.
  function automatic logic [4:0] x_mask(input rate_e r);
    case (r)
      RATE_1_2: x_mask = 5'b00001;
      RATE_2_3: x_mask = 5'b00001;
      RATE_3_4: x_mask = 5'b00101;
      default:  x_mask = 5'b10101;
    endcase
  endfunction

  function automatic logic [4:0] y_mask(input rate_e r);
    case (r)
      RATE_1_2: y_mask = 5'b00001;
      RATE_2_3: y_mask = 5'b00011;
      RATE_3_4: y_mask = 5'b00011;
      default:  y_mask = 5'b01011;
    endcase
  endfunction

  function automatic logic [2:0] period(input rate_e r);
    case (r)
      RATE_1_2: period = 3'd1;
      RATE_2_3: period = 3'd2;
      RATE_3_4: period = 3'd3;
      default:  period = 3'd5;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_punct_enc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cc_core : K=7 shift register and X/Y parity generation                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cc_core import cc_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic step,
  input  logic b,
  output logic x,
  output logic y
);

  logic [K-2:0] sr;
  logic [K-2:0] sr_eff;
  logic [K-1:0] win;

  // A clear in the same cycle as a step encodes against an all-zero history.
  assign sr_eff = clear ? '0 : sr;

  always_comb begin
    win[K-1] = b;
    for (int i = 0; i < K-1; i++) begin
      win[K-2-i] = sr_eff[i];
    end
  end

  assign x = ^(win & G1);
  assign y = ^(win & G2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (step) begin
      sr <= {sr_eff[K-3:0], b};
    end else if (clear) begin
      sr <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cc_punct_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cc_punct_enc : convolutional encoder with puncturing and word packing |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cc_punct_enc import cc_pkg::*; #(
  parameter int OUT_W     = 8,
  parameter int TAIL_LEN  = 6,
  parameter int ZERO_TAIL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_bit,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [1:0]                 cc_rate,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(OUT_W+1)-1:0] out_nbits
);

  localparam int ACC_W = OUT_W + 1;
  localparam int CW    = $clog2(OUT_W + 2);
  localparam int NBW   = $clog2(OUT_W + 1);
  localparam int TW    = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  logic [1:0]       state, state_nx;
  rate_e            rate_q, rate_cur;
  logic [2:0]       phase, phase_cur, phase_nx;
  logic [TW-1:0]    tail_cnt;
  logic [ACC_W-1:0] acc, acc_sh;
  logic [CW-1:0]    acc_cnt, cnt_sh;
  logic [4:0]       xm, ym;
  logic [1:0]       nb, nb_cnt;
  logic [NBW-1:0]   move_nbits;
  logic idle_acc, run_acc, tail_step, step, end_burst, tail_done;
  logic enc_bit, x, y, keep_x, keep_y, room, out_free, move, move_last, clear;

  assign room      = acc_cnt <= CW'(OUT_W - 1);
  assign idle_acc  = (state == ST_IDLE) && in_valid;
  assign run_acc   = (state == ST_RUN) && in_valid && room;
  assign tail_step = (state == ST_TAIL) && room;
  assign step      = idle_acc | run_acc | tail_step;
  assign end_burst = (idle_acc | run_acc) && in_last;
  assign tail_done = tail_step && (tail_cnt == TW'(TAIL_LEN - 1));
  assign enc_bit   = (state == ST_TAIL) ? 1'b0 : in_bit;
  assign clear     = (state == ST_IDLE);

  // The first bit of a burst uses the live rate and phase 0.
  assign rate_cur  = (state == ST_IDLE) ? rate_e'(cc_rate) : rate_q;
  assign phase_cur = (state == ST_IDLE) ? 3'd0 : phase;
  assign phase_nx  = (phase_cur == period(rate_cur) - 3'd1) ? 3'd0 : phase_cur + 3'd1;
  assign xm        = x_mask(rate_cur);
  assign ym        = y_mask(rate_cur);
  assign keep_x    = step && xm[phase_cur];
  assign keep_y    = step && ym[phase_cur];

  cc_core u_core (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (step),
    .b     (enc_bit),
    .x     (x),
    .y     (y)
  );

  always_comb begin
    nb     = 2'b00;
    nb_cnt = 2'd0;
    if (keep_x && keep_y) begin
      nb     = {y, x};
      nb_cnt = 2'd2;
    end else if (keep_x) begin
      nb     = {1'b0, x};
      nb_cnt = 2'd1;
    end else if (keep_y) begin
      nb     = {1'b0, y};
      nb_cnt = 2'd1;
    end
  end

  // Bits above acc_cnt are always zero, so a residual word comes out zero-padded.
  assign out_free   = !out_valid || out_ready;
  assign move       = out_free && ((acc_cnt >= CW'(OUT_W)) ||
                                   ((state == ST_DRAIN) && (acc_cnt != '0)));
  assign move_nbits = (acc_cnt >= CW'(OUT_W)) ? NBW'(OUT_W) : NBW'(acc_cnt);
  assign move_last  = (state == ST_DRAIN) && (acc_cnt <= CW'(OUT_W));
  assign acc_sh     = move ? (acc >> OUT_W) : acc;
  assign cnt_sh     = move ? (acc_cnt - CW'(move_nbits)) : acc_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      acc_cnt  <= '0;
      phase    <= 3'd0;
      rate_q   <= RATE_1_2;
      tail_cnt <= '0;
    end else begin
      acc     <= acc_sh | (ACC_W'(nb) << cnt_sh);
      acc_cnt <= cnt_sh + CW'(nb_cnt);
      if (step)          phase    <= phase_nx;
      if (idle_acc)      rate_q   <= rate_cur;
      if (end_burst)     tail_cnt <= '0;
      else if (tail_step) tail_cnt <= tail_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (move) begin
      out_data  <= acc[OUT_W-1:0];
      out_nbits <= move_nbits;
      out_last  <= move_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (idle_acc) state_nx = in_last ? ((ZERO_TAIL != 0) ? ST_TAIL : ST_DRAIN) : ST_RUN;
      ST_RUN:   if (end_burst) state_nx = (ZERO_TAIL != 0) ? ST_TAIL : ST_DRAIN;
      ST_TAIL:  if (tail_done) state_nx = ST_DRAIN;
      default:  if (out_valid && out_ready && out_last) state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: in_ready = 1'b1;
        ST_RUN:  in_ready = room;
        default: in_ready = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cc_punct_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cc_punct_enc : self-checking bench for cc_punct_enc               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cc_punct_enc;

  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [1:0] cc_rate = 2'b00;
  logic in_ready, out_valid, out_last;
  logic [OUT_W-1:0] out_data;
  logic [3:0] out_nbits;

  typedef struct { logic [7:0] d; int n; logic l; } word_t;
  typedef struct { logic [1:0] rate; bit b; logic [7:0] d0; int n0; logic [7:0] d1; int n1; } vec_t;

  word_t got[$];
  word_t prev;
  int n_cmp = 0, n_fail = 0, stall_cnt = 0;
  bit rand_ready = 0, got_last = 0, saw_ir_low = 0, hold_prev = 0;

  always #5 clk = ~clk;

  cc_punct_enc #(.OUT_W(OUT_W), .TAIL_LEN(6), .ZERO_TAIL(1)) dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .cc_rate(cc_rate), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_nbits(out_nbits)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: direct polynomial convolution over the whole burst, then puncture and chunk.
  task automatic model(input bit data[$], input int rate, output word_t exp[$]);
    string xp[4];
    string yp[4];
    bit u[$];
    bit c[$];
    bit [6:0] g1, g2;
    int per;
    xp = '{"1", "10", "101", "10101"};
    yp = '{"1", "11", "110", "11010"};
    g1 = 7'o171;
    g2 = 7'o133;
    u = data;
    for (int i = 0; i < 6; i++) u.push_back(1'b0);
    per = xp[rate].len();
    for (int n = 0; n < u.size(); n++) begin
      bit x, y;
      x = 0;
      y = 0;
      for (int j = 0; j < 7; j++) begin
        if (n - j >= 0) begin
          x ^= g1[6-j] & u[n-j];
          y ^= g2[6-j] & u[n-j];
        end
      end
      if (xp[rate].getc(n % per) == "1") c.push_back(x);
      if (yp[rate].getc(n % per) == "1") c.push_back(y);
    end
    exp.delete();
    for (int k = 0; k < c.size(); k += 8) begin
      word_t w;
      w.d = '0;
      w.n = (c.size() - k < 8) ? c.size() - k : 8;
      for (int i = 0; i < w.n; i++) w.d[i] = c[k+i];
      w.l = (k + 8 >= c.size());
      exp.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev.d);
        chk("hold_nbits", out_nbits, prev.n);
        chk("hold_last", out_last, prev.l);
      end
      if (stall_cnt > 0 && in_valid && !in_ready) saw_ir_low = 1;
      if (out_valid && out_ready) begin
        got.push_back('{out_data, int'(out_nbits), out_last});
        if (out_last) got_last = 1;
      end
      hold_prev = out_valid && !out_ready;
      prev = '{out_data, int'(out_nbits), out_last};
    end else begin
      hold_prev = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic send(input bit data[$], input logic [1:0] rate, input int toggle_at, input int stall_at);
    bit acc;
    got.delete();
    got_last = 0;
    for (int i = 0; i < data.size(); i++) begin
      in_valid = 1'b1;
      in_bit   = data[i];
      in_last  = (i == data.size() - 1);
      if (i == 0) cc_rate = rate;
      else if (i == toggle_at) cc_rate = ~rate;
      if (i == stall_at) stall_cnt = 10;
      acc = 0;
      for (int t = 0; t < 500 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: got no in_ready expected accept of bit %0d", i);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!got_last && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!got_last) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no out_last expected out_last within 3000 cycles", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input string tag, input bit data[$], input int rate);
    word_t exp[$];
    model(data, rate, exp);
    chk({tag, "_nwords"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk({tag, "_data"}, got[i].d, exp[i].d);
      chk({tag, "_nbits"}, got[i].n, exp[i].n);
      chk({tag, "_last"}, got[i].l, exp[i].l);
    end
  endtask

  task automatic run(input string tag, input bit data[$], input logic [1:0] rate,
                     input int toggle_at, input int stall_at);
    send(data, rate, toggle_at, stall_at);
    wait_done(tag);
    check_burst(tag, data, int'(rate));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_nbits"}, out_nbits, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    vec_t vt[5];
    bit d[$];
    bit r[$];
    int len;
    logic [1:0] rt;

    vt[0] = '{2'b00, 1'b1, 8'hF7, 8, 8'h38, 6};
    vt[1] = '{2'b10, 1'b1, 8'h3B, 8, 8'h03, 2};
    vt[2] = '{2'b01, 1'b1, 8'h3B, 8, 8'h07, 3};
    vt[3] = '{2'b11, 1'b1, 8'h9B, 8, 8'h01, 1};
    vt[4] = '{2'b00, 1'b0, 8'h00, 8, 8'h00, 6};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      d = '{vt[i].b};
      send(d, vt[i].rate, -1, -1);
      wait_done("vec");
      chk("vec_nwords", got.size(), 2);
      if (got.size() == 2) begin
        chk("vec_d0", got[0].d, vt[i].d0);
        chk("vec_n0", got[0].n, vt[i].n0);
        chk("vec_l0", got[0].l, 0);
        chk("vec_d1", got[1].d, vt[i].d1);
        chk("vec_n1", got[1].n, vt[i].n1);
        chk("vec_l1", got[1].l, 1);
      end
    end

    r.delete();
    for (int i = 0; i < 48; i++) r.push_back(1'($urandom_range(0, 1)));
    run("r48_half", r, 2'b00, -1, -1);
    chk("r48_half_count", got.size(), 14);
    if (got.size() == 14) chk("r48_half_tail_nbits", got[13].n, 4);
    run("r48_56", r, 2'b11, -1, -1);
    chk("r48_56_count", got.size(), 9);
    if (got.size() == 9) chk("r48_56_tail_nbits", got[8].n, 1);

    r.delete();
    for (int i = 0; i < 40; i++) r.push_back(1'($urandom_range(0, 1)));
    saw_ir_low = 0;
    run("stall", r, 2'b10, -1, 20);
    chk("stall_in_ready_fell", saw_ir_low, 1);

    run("toggle", r, 2'b01, 10, -1);
    r.delete();
    for (int i = 0; i < 20; i++) r.push_back(1'($urandom_range(0, 1)));
    run("after_toggle", r, 2'b10, -1, -1);

    d = '{1'b1};
    send(d, 2'b00, -1, -1);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    chk("mid_reset_no_last", got_last, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run("post_reset", d, 2'b00, -1, -1);
    if (got.size() == 2) begin
      chk("post_reset_w0", got[0].d, 8'hF7);
      chk("post_reset_w1", got[1].d, 8'h38);
    end

    rand_ready = 1;
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(1, 40);
      rt  = 2'($urandom_range(0, 3));
      r.delete();
      for (int i = 0; i < len; i++) r.push_back(1'($urandom_range(0, 1)));
      run("rand", r, rt, -1, -1);
    end
    rand_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cc_punct_enc.md
Name: cc_punct_enc

Overview:
- Parametrised 802.16 OFDM convolutional encoder with puncturing and output packing.
- Encoder: K=7, generators G1=171o (X) and G2=133o (Y).
- Function: applies the rate-dependent puncture pattern, appends a zero tail, and packs surviving bits into OUT_W-bit words with a valid/ready handshake.
- Position: follows RS encode (or bypass) and feeds the interleaver.

Parameters:
- OUT_W, 8: output word width in bits; legal range >= 2.
- TAIL_LEN, 6: number of zero tail bits appended after in_last; equals K-1.
- ZERO_TAIL, 1: 1 appends the tail; 0 ends the burst directly after the last data bit, leaving tail-biting to the upstream block.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_bit  in  1  data bit.
- in_valid  in  1  in_bit is valid.
- in_last  in  1  qualifies the final data bit of a burst.
- in_ready  out  1  block accepts in_bit this cycle.
- cc_rate  in  2  rate select: 00=1/2, 01=2/3, 10=3/4, 11=5/6. Latched at burst start.
- out_data  out  OUT_W  packed coded bits; first bit at out_data[0].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  final word of the burst.
- out_nbits  out  $clog2(OUT_W+1)  valid bits in out_data; OUT_W except possibly on the last word.

Behaviour:
- Timing: all state updates on posedge clk. Reset clears shift register, phase counter, accumulator, FSM.
- Reset values: out_valid=0, out_last=0, out_data=0, out_nbits=0, in_ready=0.
- Encoder: s[0] holds the newest previous bit.
  - x = b^s0^s1^s2^s5
  - y = b^s1^s2^s4^s5
  - s <= {s[4:0], b}
- Puncture period P = 1/2/3/5 for rates 00/01/10/11. Phase counter 0..P-1 resets at burst start.
- Keep masks per phase, X;Y:
  - 1/2: 1;1
  - 2/3: 10;11
  - 3/4: 101;110
  - 5/6: 10101;11010
- Kept bits of one step go out X before Y.
- Accumulator: OUT_W+1 bits deep, count acc_cnt.
  - Each encoder step appends 0-2 bits at positions acc_cnt upward.
  - When acc_cnt >= OUT_W and the output register is empty or draining, move the low OUT_W bits out and shift down the remainder.
  - Moving a word and appending in the same cycle is allowed.
- Output handshake:
  - Transfer occurs when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data, out_nbits and out_last hold stable.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch cc_rate, clear the shift register to 0 and phase to 0, encode the bit, then go to RUN. If in_last is also set, go to TAIL (or DRAIN if ZERO_TAIL=0) instead.
  - RUN: in_ready = (acc_cnt <= OUT_W-1). Each accepted bit is one encoder step. An accepted bit with in_last goes to TAIL (or DRAIN).
  - TAIL: in_ready=0. Injects TAIL_LEN zero bits, one per cycle when acc_cnt <= OUT_W-1. Tail bits are punctured with the continuing phase. After the last tail step, go to DRAIN.
  - DRAIN: in_ready=0. Emit full words, then any residual bits as a final word: zero-padded, out_nbits = residue, out_last=1. If the residue is 0, the last full word carries out_last=1. After the out_last transfer, go to IDLE.
- cc_rate changes outside IDLE are ignored.
- Latency: first coded bits reach the accumulator the cycle after acceptance. A full word is presented 1 cycle after acc_cnt reaches OUT_W.
- Reset mid-burst: the burst is discarded, with no out_last; the next burst starts cleanly.
- Back-to-back bursts: IDLE accepts a new bit the cycle after the final out_last transfer.

Decomposition:
- Package cc_pkg:
  - rate enum (RATE_1_2 .. RATE_5_6)
  - puncture mask constants (X and Y per rate, 5-bit)
  - period table
  - generator taps G1/G2
  - K=7
- Sub-module cc_core: 6-bit shift register plus x/y generation, with step enable and clear; no handshake.

Test Plan:
- Rate 1/2, OUT_W=8, single bit 1 with in_last, out_ready=1 -> words 0xF7 (nbits 8), then 0x38 (nbits 6, out_last=1).
- Rate 3/4, same stimulus -> coded sequence 1101110011; words 0x3B (nbits 8), then 0x03 (nbits 2, out_last=1).
- Rate 1/2, 48 random bits -> 108 coded bits as 13 words plus final nbits=4. Contents match the reference model. Rate 5/6 with the same data -> 65 bits (8 words, final nbits=1).
- Backpressure: out_ready=0 for 10 cycles mid-burst -> out_data stable, in_ready falls once the accumulator fills, no bit lost or duplicated vs model.
- cc_rate toggled mid-burst -> output matches the rate latched at the first bit. Next burst uses the new rate.
- reset asserted in TAIL -> all outputs 0 immediately. The following rate-1/2 single-1 burst again yields 0xF7 / 0x38.
